// File: rtl/ofdm_carrier_extract_if.sv
// Stream bundle for ofdm_carrier_extract: FFT-order bins in, data carriers out.
// The slave modport is the block's view, the master modport is the driver/sink view.
interface ofdm_carrier_extract_if #(
   parameter int DATA_SIZE = 16
);
   logic signed [DATA_SIZE-1:0] i_data_i;
   logic signed [DATA_SIZE-1:0] i_data_q;
   logic                        i_valid;
   logic                        i_sync_frame;
   logic                        o_ready;

   logic signed [DATA_SIZE-1:0] o_data_i;
   logic signed [DATA_SIZE-1:0] o_data_q;
   logic signed [7:0]           o_carrier;
   logic [1:0]                  o_bits;
   logic                        o_valid;
   logic                        o_last;
   logic                        i_ready;
   logic                        o_overflow;

   modport slave (
      input  i_data_i, i_data_q, i_valid, i_sync_frame, i_ready,
      output o_ready, o_data_i, o_data_q, o_carrier, o_bits, o_valid, o_last, o_overflow
   );

   modport master (
      output i_data_i, i_data_q, i_valid, i_sync_frame, i_ready,
      input  o_ready, o_data_i, o_data_q, o_carrier, o_bits, o_valid, o_last, o_overflow
   );
endinterface

// File: rtl/ofdm_carrier_extract.sv
// Buffers one 256-bin OFDM symbol, then streams the 192 data carriers (-100..+100, no DC/pilots).
// Optional QPSK hard decision on o_bits when OFDM_CARRIER_QPSK_DEMAP_EN is defined.
module ofdm_carrier_extract #(
   parameter int DATA_SIZE = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   ofdm_carrier_extract_if.slave bus
);

   typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [7:0]            r_wr_cnt;
   logic signed [7:0]     r_rd_car;
   logic                  r_rd_done;
   logic [DATA_SIZE-1:0]  r_buf_i [256];
   logic [DATA_SIZE-1:0]  r_buf_q [256];

   logic signed [DATA_SIZE-1:0] r_data_i;
   logic signed [DATA_SIZE-1:0] r_data_q;
   logic signed [7:0]           r_carrier;
   logic                        r_valid;
   logic                        r_last;
   logic                        r_overflow;

   logic                  w_ready;
   logic                  w_wr_en;
   logic                  w_ovf_beat;
   logic                  w_adv;
   logic                  w_load;
   logic                  w_xfer_last;
   logic [7:0]            w_wr_addr;
   logic [7:0]            w_rd_addr;
   logic signed [7:0]     w_car_p1;
   logic signed [7:0]     w_car_next;

   // DC and the four pilot pairs are never emitted; no two of them are adjacent.
   function automatic logic f_skip(input logic signed [7:0] c);
      logic [7:0] a;
      a = c[7] ? 8'(-c) : 8'(c);
      return (a == 8'd0) || (a == 8'd13) || (a == 8'd38) || (a == 8'd63) || (a == 8'd88);
   endfunction

   assign w_wr_addr   = bus.i_sync_frame ? 8'd0 : r_wr_cnt;
   assign w_rd_addr   = $unsigned(r_rd_car);
   assign w_car_p1    = r_rd_car + 8'sd1;
   assign w_car_next  = f_skip(w_car_p1) ? (r_rd_car + 8'sd2) : w_car_p1;
   assign w_adv       = !r_valid || bus.i_ready;
   assign w_xfer_last = r_valid && r_last && bus.i_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= COLLECT;
      else         r_state <= w_state_next;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         COLLECT: if (bus.i_valid && (w_wr_addr == 8'd255)) w_state_next = EMIT;
         EMIT:    if (w_xfer_last)                          w_state_next = COLLECT;
         default:                                           w_state_next = COLLECT;
      endcase
   end

   always_comb begin
      w_ready    = (r_state == COLLECT);
      w_wr_en    = w_ready && bus.i_valid;
      w_ovf_beat = !w_ready && bus.i_valid;
      w_load     = (r_state == EMIT) && !r_rd_done && w_adv;
   end

   // Write index wraps 255 -> 0, which clears it on the beat that completes a symbol.
   always_ff @(posedge i_clk) begin
      if (i_reset)      r_wr_cnt <= 8'd0;
      else if (w_wr_en) r_wr_cnt <= w_wr_addr + 8'd1;
   end

   // NOTE: the symbol buffer carries no reset; it is fully rewritten before any read.
   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         r_buf_i[w_wr_addr] <= bus.i_data_i;
         r_buf_q[w_wr_addr] <= bus.i_data_q;
      end
   end

   // The read pointer is the carrier number itself; its two's complement bits are the bin index.
   always_ff @(posedge i_clk) begin
      if (i_reset || (r_state == COLLECT)) begin
         r_rd_car  <= -8'sd100;
         r_rd_done <= 1'b0;
      end else if (w_load) begin
         r_rd_car  <= w_car_next;
         r_rd_done <= (r_rd_car == 8'sd100);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_data_i   <= '0;
         r_data_q   <= '0;
         r_carrier  <= '0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_load) begin
            r_data_i  <= r_buf_i[w_rd_addr];
            r_data_q  <= r_buf_q[w_rd_addr];
            r_carrier <= r_rd_car;
            r_valid   <= 1'b1;
            r_last    <= (r_rd_car == 8'sd100);
         end else if (w_adv) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end
         if (w_ovf_beat) r_overflow <= 1'b1;
      end
   end

`ifdef OFDM_CARRIER_QPSK_DEMAP_EN
   logic [1:0] r_bits;

   always_ff @(posedge i_clk) begin
      if (i_reset)     r_bits <= 2'b00;
      else if (w_load) r_bits <= {r_buf_i[w_rd_addr][DATA_SIZE-1], r_buf_q[w_rd_addr][DATA_SIZE-1]};
   end

   assign bus.o_bits = r_bits;
`else
   assign bus.o_bits = 2'b00;
`endif

   assign bus.o_ready    = w_ready;
   assign bus.o_data_i   = r_data_i;
   assign bus.o_data_q   = r_data_q;
   assign bus.o_carrier  = r_carrier;
   assign bus.o_valid    = r_valid;
   assign bus.o_last     = r_last;
   assign bus.o_overflow = r_overflow;

endmodule

// File: tb/tb_ofdm_carrier_extract.sv
// Self-checking bench for ofdm_carrier_extract: random symbols against a carrier-list model.
// Honours OFDM_CARRIER_QPSK_DEMAP_EN for the expected o_bits.
module tb_ofdm_carrier_extract;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ofdm_carrier_extract_if #(.DATA_SIZE(DW)) bus ();
   ofdm_carrier_extract #(.DATA_SIZE(DW)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

   typedef struct {
      int             car;
      logic [DW-1:0]  di;
      logic [DW-1:0]  dq;
      logic [1:0]     bits;
   } samp_t;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] bin_i [256];
   logic [DW-1:0] bin_q [256];
   samp_t         exp_q [$];

   int            got_first_car, got_first_i, got_last_car, got_last_i, got_n_last;
   logic [1:0]    got_c1_bits;
   bit            seen_m88, seen_13;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit is_data_carrier(input int c);
      int a;
      a = (c < 0) ? -c : c;
      if (a == 0 || a > 100) return 1'b0;
      return !(a == 13 || a == 38 || a == 63 || a == 88);
   endfunction

   // Reference list: every data carrier in ascending order, sample taken from its FFT bin.
   task automatic build_expected();
      samp_t s;
      int    k;
      exp_q.delete();
      for (int c = -100; c <= 100; c++) begin
         if (is_data_carrier(c)) begin
            k      = (c < 0) ? c + 256 : c;
            s.car  = c;
            s.di   = bin_i[k];
            s.dq   = bin_q[k];
`ifdef OFDM_CARRIER_QPSK_DEMAP_EN
            s.bits = {bin_i[k][DW-1], bin_q[k][DW-1]};
`else
            s.bits = 2'b00;
`endif
            exp_q.push_back(s);
         end
      end
   endtask

   task automatic fill_random();
      for (int k = 0; k < 256; k++) begin
         bin_i[k] = DW'($urandom);
         bin_q[k] = DW'($urandom);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"},    64'(bus.o_valid),    64'd0);
      check({tag, "_last"},     64'(bus.o_last),     64'd0);
      check({tag, "_overflow"}, 64'(bus.o_overflow), 64'd0);
      check({tag, "_data_i"},   64'(bus.o_data_i),   64'd0);
      check({tag, "_data_q"},   64'(bus.o_data_q),   64'd0);
      check({tag, "_carrier"},  64'(bus.o_carrier),  64'd0);
      check({tag, "_bits"},     64'(bus.o_bits),     64'd0);
      check({tag, "_ready"},    64'(bus.o_ready),    64'd1);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_sync_frame = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Drives n beats back to back from bin_i/bin_q; o_ready must stay high throughout.
   task automatic feed(input bit sync_first, input int n, input bit expect_emit);
      int drops = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (!bus.o_ready) drops++;
         bus.i_valid      = 1'b1;
         bus.i_sync_frame = sync_first && (k == 0);
         bus.i_data_i     = bin_i[k];
         bus.i_data_q     = bin_q[k];
      end
      @(negedge clk);
      bus.i_valid      = 1'b0;
      bus.i_sync_frame = 1'b0;
      check("ready_in_collect", 64'(drops), 64'd0);
      if (expect_emit) check("emit_entry_ready", 64'(bus.o_ready), 64'd0);
   endtask

   // Sinks the symbol; stop_after=0 means run to o_last.
   task automatic drain(input bit toggle, input bit ovf, input int stop_after);
      int          idx = 0, cyc = 0, first_cyc = -1, last_cyc = -1;
      bit          done = 1'b0, prev_stall = 1'b0, rdy;
      logic [43:0] snap, prev_snap, exp_snap;
      got_first_car = 999; got_first_i = 0; got_last_car = 999; got_last_i = 0;
      got_n_last = 0; got_c1_bits = 2'bxx; seen_m88 = 1'b0; seen_13 = 1'b0;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         snap = {bus.o_valid, bus.o_carrier, bus.o_data_i, bus.o_data_q, bus.o_bits, bus.o_last};
         if (prev_stall) check("stall_hold", 64'(snap), 64'(prev_snap));
         rdy = toggle ? cyc[0] : 1'b1;
         bus.i_ready = rdy;
         if (ovf) begin
            bus.i_valid      = (cyc == 2) || ($urandom_range(0, 3) == 0);
            bus.i_sync_frame = 1'($urandom);
            bus.i_data_i     = DW'($urandom);
            bus.i_data_q     = DW'($urandom);
         end
         if (bus.o_valid && first_cyc < 0) first_cyc = cyc;
         if (bus.o_valid && rdy) begin
            if (idx < exp_q.size()) begin
               exp_snap = {1'b1, 8'(exp_q[idx].car), exp_q[idx].di, exp_q[idx].dq,
                           exp_q[idx].bits, 1'(idx == exp_q.size() - 1)};
               check($sformatf("sample[%0d]", idx), 64'(snap), 64'(exp_snap));
            end
            if (idx == 0) begin got_first_car = int'(bus.o_carrier); got_first_i = int'(bus.o_data_i); end
            if (bus.o_last) begin
               got_last_car = int'(bus.o_carrier); got_last_i = int'(bus.o_data_i); got_n_last++;
               done = 1'b1;
            end
            if (bus.o_carrier == -8'sd88) seen_m88 = 1'b1;
            if (bus.o_carrier == 8'sd13)  seen_13  = 1'b1;
            if (bus.o_carrier == 8'sd1)   got_c1_bits = bus.o_bits;
            idx++;
            last_cyc = cyc;
            if (idx == stop_after) done = 1'b1;
         end
         prev_stall = bus.o_valid && !rdy;
         prev_snap  = snap;
      end
      bus.i_valid      = 1'b0;
      bus.i_sync_frame = 1'b0;
      check("drain_done", 64'(done), 64'd1);
      check("first_valid_latency", 64'(first_cyc >= 1 && first_cyc <= 3), 64'd1);
      if (stop_after == 0) begin
         check("xfer_count", 64'(idx), 64'd192);
         if (!toggle) check("one_per_cycle", 64'(last_cyc - first_cyc + 1), 64'd192);
         @(negedge clk);
         bus.i_ready = 1'b1;
         check("ready_after_last", 64'(bus.o_ready), 64'd1);
         check("valid_after_last", 64'(bus.o_valid), 64'd0);
      end
      bus.i_ready = 1'b1;
   endtask

   initial begin
      rst              = 1'b1;
      bus.i_valid      = 1'b0;
      bus.i_sync_frame = 1'b0;
      bus.i_ready      = 1'b1;
      bus.i_data_i     = '0;
      bus.i_data_q     = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_state("reset");

      // Ramp symbol, free-flowing sink.
      for (int k = 0; k < 256; k++) begin
         bin_i[k] = DW'(k);
         bin_q[k] = DW'(-k);
      end
      build_expected();
      feed(1'b0, 256, 1'b1);
      drain(1'b0, 1'b0, 0);
      check("ramp_first_car", 64'(got_first_car), 64'(-100));
      check("ramp_first_i",   64'(got_first_i),   64'd156);
      check("ramp_last_car",  64'(got_last_car),  64'd100);
      check("ramp_last_i",    64'(got_last_i),    64'd100);
      check("ramp_n_last",    64'(got_n_last),    64'd1);
      check("ramp_no_m88",    64'(seen_m88),      64'd0);
      check("ramp_no_p13",    64'(seen_13),       64'd0);

      // Random symbol, sink toggling every cycle, carrier +1 carries (-5, 7).
      fill_random();
      bin_i[1] = DW'(-5);
      bin_q[1] = DW'(7);
      build_expected();
      feed(1'b1, 256, 1'b1);
      drain(1'b1, 1'b0, 0);
`ifdef OFDM_CARRIER_QPSK_DEMAP_EN
      check("qpsk_c1", 64'(got_c1_bits), 64'(2'b10));
`else
      check("qpsk_c1", 64'(got_c1_bits), 64'(2'b00));
`endif

      // Bins arriving while emitting are dropped and flagged.
      fill_random();
      build_expected();
      feed(1'b0, 256, 1'b1);
      drain(1'b0, 1'b1, 0);
      check("overflow_set", 64'(bus.o_overflow), 64'd1);
      fill_random();
      build_expected();
      feed(1'b0, 256, 1'b1);
      drain(1'b0, 1'b0, 0);
      check("overflow_sticky", 64'(bus.o_overflow), 64'd1);
      pulse_reset();
      check_reset_state("ovf_clear");

      // Reset part-way through a symbol abandons the rest.
      fill_random();
      build_expected();
      feed(1'b0, 256, 1'b1);
      drain(1'b0, 1'b0, 50);
      pulse_reset();
      check_reset_state("mid_emit_reset");
      fill_random();
      build_expected();
      feed(1'b0, 256, 1'b1);
      drain(1'b1, 1'b0, 0);
      check("after_reset_first_car", 64'(got_first_car), 64'(-100));

      // Frame sync at write index 40 restarts collection.
      fill_random();
      feed(1'b0, 40, 1'b0);
      fill_random();
      build_expected();
      feed(1'b1, 256, 1'b1);
      drain(1'b0, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/ofdm_carrier_extract.md
OFDM_CARRIER_EXTRACT -- requirements
Module: ofdm_carrier_extract

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 16, giving the I/Q sample width in bits (signed two's complement).
REQ-002 The block SHALL have port i_clk, input, 1 bit: clock, all logic on the rising edge.
REQ-003 The block SHALL have port i_reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have ports i_data_i and i_data_q, input, DATA_SIZE each: equalized bin, FFT order.
REQ-005 The block SHALL have port i_valid, input, 1 bit: input bin qualifier.
REQ-006 The block SHALL have port i_sync_frame, input, 1 bit: when high with i_valid, the current bin is bin 0.
REQ-007 The block SHALL have port o_ready, output, 1 bit: block accepts input bins.
REQ-008 The block SHALL have ports o_data_i and o_data_q, output, DATA_SIZE each: data-carrier sample.
REQ-009 The block SHALL have port o_carrier, output, 8 bits: signed carrier number of o_data.
REQ-010 The block SHALL have port o_bits, output, 2 bits: QPSK hard decision.
REQ-011 The block SHALL have ports o_valid and o_last, output, 1 bit each: output qualifier and last carrier of symbol.
REQ-012 The block SHALL have port i_ready, input, 1 bit: downstream accepts output.
REQ-013 The block SHALL have port o_overflow, output, 1 bit: sticky, a bin was dropped.

Function
REQ-014 The block SHALL map write index k (0..255) to carrier c=k for k<128 and c=k-256 for k>=128.
REQ-015 The FSM SHALL have states COLLECT and EMIT; o_ready SHALL equal (state==COLLECT).
REQ-016 In COLLECT, each i_valid beat SHALL write the bin at the write counter, then increment it; i_valid with i_sync_frame SHALL write at index 0 and set the counter to 1.
REQ-017 The write beat at index 255 SHALL move the FSM to EMIT on the next cycle and clear the write counter.
REQ-018 In EMIT, the block SHALL output carriers -100..-1 then +1..+100 ascending, skipping DC, guards and pilots ±13, ±38, ±63, ±88, i.e. 192 samples per symbol.
REQ-019 The first o_valid SHALL rise no later than 3 cycles after EMIT entry; with i_ready held high, the block SHALL present one sample per cycle thereafter.
REQ-020 o_data, o_carrier, o_bits and o_last SHALL hold stable while o_valid=1 and i_ready=0, and no sample SHALL be lost or repeated.
REQ-021 A transfer SHALL occur on a cycle with o_valid=1 and i_ready=1.
REQ-022 o_last SHALL be 1 only with carrier +100; after its transfer, the FSM SHALL return to COLLECT on the next cycle.
REQ-023 i_valid while o_ready=0 SHALL drop the bin, leave the buffer unchanged and set o_overflow; only reset SHALL clear o_overflow.
REQ-024 The block SHALL pass samples unmodified, with no arithmetic on data.

Reset
REQ-025 On i_reset, the FSM SHALL enter COLLECT and the write and read counters SHALL clear.
REQ-026 On i_reset, o_valid, o_last and o_overflow SHALL be 0, o_data_i/q, o_carrier and o_bits SHALL be 0, and o_ready SHALL be 1 on the following cycle.
REQ-027 Reset in EMIT SHALL abandon the remaining carriers without emitting them, and the next symbol SHALL start at index 0.
REQ-028 Buffer memory SHALL need no reset.

Configuration
REQ-029 With macro OFDM_CARRIER_QPSK_DEMAP_EN defined, o_bits SHALL be {o_data_i sign bit, o_data_q sign bit}, aligned with o_data.
REQ-030 Without OFDM_CARRIER_QPSK_DEMAP_EN, o_bits SHALL be constant 2'b00 and no decision logic SHALL be built.

Verification
REQ-031 Feed 256 bins with i=k, q=-k and i_ready=1 -> 192 outputs; first output is carrier -100 with i=156, last is carrier +100 with i=100 and o_last=1; carriers -88 and 13 are absent.
REQ-032 Repeat REQ-031 toggling i_ready 1/0 every cycle -> the same 192-sample sequence, with outputs stable during stalls.
REQ-033 Assert i_valid during EMIT -> o_overflow=1 and the emitted sequence is unchanged; i_reset then clears o_overflow.
REQ-034 Assert i_reset after 50 emitted samples, then send a new symbol -> the first output is carrier -100 of the new symbol.
REQ-035 With the macro defined, input carrier +1 = (-5, 7) -> o_bits=2'b10; without the macro, o_bits=2'b00.
REQ-036 Assert i_sync_frame at write index 40 -> collection restarts at index 0 and EMIT begins only after 256 further bins.
